// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Purpose  : Constants and types shared by the execute and write-back stages.
//             WSEL_* are bit indices into the wselector bundle; PC_STEP is the
//             fall-through increment; ZERO_REG is the hardwired-zero register.
//  Revision : 1.0  initial release
// ============================================================================
package core_pkg;

  localparam int          WSEL_REG = 1;
  localparam int          WSEL_PC  = 2;
  localparam int          WSEL_OUT = 3;
  localparam logic [4:0]  ZERO_REG = 5'd0;
  localparam logic [31:0] PC_STEP  = 32'h4;

  // Write-back commit state: IDLE accepts a bundle, STALL holds an OUT byte
  // until the byte queue has room.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : out_fifo
//  Purpose  : Circular byte queue feeding the UART sender.
//  Ports    : clk, rstn        - clock, synchronous active-low reset
//             push, push_data  - enqueue one byte
//             pop              - dequeue head byte (caller guarantees !empty)
//             head             - byte at queue head
//             empty, full      - occupancy flags
//             count            - number of bytes held (0..DEPTH)
//  Revision : 1.0  initial release
// ============================================================================
module out_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [AW:0]    C_FULL = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Pointers are exactly log2(DEPTH) wide, so they wrap without a compare.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= push_data;
  end

  assign head  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == C_FULL);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/write_back.sv
`default_nettype none
// ============================================================================
//  Module   : write_back
//  Purpose  : Commits an execute-stage result: register-file write strobe,
//             next-PC update and an OUT byte queue drained over valid/ready.
//             done is a level that rises when the commit has fully completed.
//  Ports    : clk, rstn                     - clock, sync active-low reset
//             enable                        - one-cycle bundle-valid pulse
//             wselector, data, rd_in,
//             pc_in, pc_current             - result bundle
//             done                          - completion level
//             reg_we, reg_waddr, reg_wdata  - register-file write port
//             pc_out                        - next PC
//             out_data, out_valid, out_ready- byte stream toward the UART
//  Revision : 1.0  initial release
// ============================================================================
module write_back
  import core_pkg::*;
#(
  parameter int OUT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        done,
  input  logic [3:0]  wselector,
  input  logic [31:0] data,
  input  logic [4:0]  rd_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_current,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic [31:0] pc_out,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  wb_state_t  r_state;
  logic [7:0] r_pend;

  logic                        w_empty;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_slot;
  logic                        w_push;
  logic [7:0]                  w_push_data;
  logic [$clog2(OUT_DEPTH):0]  w_unused_count;
  logic                        w_unused_wsel0;

  assign w_unused_wsel0 = wselector[0];

  assign w_pop  = !w_empty && out_ready;
  // A slot exists if the queue is not full or the head leaves this cycle.
  assign w_slot = !w_full || w_pop;

  assign w_push = (r_state == STALL) ? w_slot
                                     : (enable && wselector[WSEL_OUT] && w_slot);
  assign w_push_data = (r_state == STALL) ? r_pend : data[7:0];

  out_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (out_data),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_unused_count)
  );

  assign out_valid = !w_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      done      <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      pc_out    <= '0;
    end else begin
      reg_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            // Register and PC commit happen now even if the OUT byte stalls.
            if (wselector[WSEL_REG] && (rd_in != ZERO_REG)) begin
              reg_we    <= 1'b1;
              reg_waddr <= rd_in;
              reg_wdata <= data;
            end
            pc_out <= wselector[WSEL_PC] ? pc_in : (pc_current + PC_STEP);
            if (wselector[WSEL_OUT] && !w_slot) begin
              r_state <= STALL;
              r_pend  <= data[7:0];
              done    <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        STALL: begin
          if (w_slot) begin
            done    <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The controller must not issue a new bundle while an OUT byte is pending.
  a_no_enable_in_stall : assert property (
    @(posedge clk) disable iff (!rstn) !((r_state == STALL) && enable)
  );

endmodule
`default_nettype wire

// File: tb/tb_write_back.sv
`default_nettype none
// ============================================================================
//  Module   : tb_write_back
//  Purpose  : Self-checking bench for write_back: directed scenarios followed
//             by randomized bundles, compared every cycle against a
//             queue-based reference model of the commit behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_write_back;

  localparam int OUT_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        done;
  logic [3:0]  wselector = '0;
  logic [31:0] data = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_current = '0;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] pc_out;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  write_back #(.OUT_DEPTH(OUT_DEPTH)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .done       (done),
    .wselector  (wselector),
    .data       (data),
    .rd_in      (rd_in),
    .pc_in      (pc_in),
    .pc_current (pc_current),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .pc_out     (pc_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected outputs plus the byte stream as a queue.
  bit          m_done;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_pc;
  bit          m_stall;
  logic [7:0]  m_pend;
  logic [7:0]  q[$];

  task automatic model_edge();
    bit popped;
    if (!rstn) begin
      m_done = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_pc = '0;
      m_stall = 0; m_pend = '0;
      q.delete();
    end else begin
      popped = (q.size() != 0) && out_ready;
      m_we = 0;
      if (popped) void'(q.pop_front());
      if (m_stall) begin
        if (q.size() < OUT_DEPTH) begin
          q.push_back(m_pend);
          m_done  = 1;
          m_stall = 0;
        end
      end else if (enable) begin
        if (wselector[1] && rd_in != 5'd0) begin
          m_we = 1; m_waddr = rd_in; m_wdata = data;
        end
        m_pc = wselector[2] ? pc_in : pc_current + 32'd4;
        if (wselector[3]) begin
          if (q.size() < OUT_DEPTH) begin
            q.push_back(data[7:0]);
            m_done = 1;
          end else begin
            m_stall = 1;
            m_pend  = data[7:0];
            m_done  = 0;
          end
        end else begin
          m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("done",      done,      m_done);
    chk("reg_we",    reg_we,    m_we);
    chk("reg_waddr", reg_waddr, m_waddr);
    chk("reg_wdata", reg_wdata, m_wdata);
    chk("pc_out",    pc_out,    m_pc);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic cyc(input logic en, input logic [3:0] ws, input logic [31:0] d,
                     input logic [4:0] rd, input logic [31:0] pci, input logic [31:0] pcc,
                     input logic rdy, input logic rn);
    @(negedge clk);
    enable = en; wselector = ws; data = d; rd_in = rd;
    pc_in = pci; pc_current = pcc; out_ready = rdy; rstn = rn;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 4'b0, 32'h0, 5'd0, 32'h0, 32'h0, rdy, 1'b1);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 4'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_done", done, 32'd0);
    chk("rst_pc", pc_out, 32'd0);

    // Plain register write with fall-through PC
    cyc(1'b1, 4'b0010, 32'hDEADBEEF, 5'd5, 32'h0, 32'h100, 1'b0, 1'b1);
    chk("tp1_we", reg_we, 32'd1);
    chk("tp1_wdata", reg_wdata, 32'hDEADBEEF);
    chk("tp1_pc", pc_out, 32'h104);
    chk("tp1_done", done, 32'd1);
    idle(1'b0);
    chk("tp1_we_drop", reg_we, 32'd0);

    // JAL-style: register write and PC write together; x0 suppressed
    cyc(1'b1, 4'b0110, 32'h108, 5'd31, 32'h2000, 32'h104, 1'b0, 1'b1);
    chk("tp2_waddr", reg_waddr, 32'd31);
    chk("tp2_pc", pc_out, 32'h2000);
    cyc(1'b1, 4'b0110, 32'h55, 5'd0, 32'h3000, 32'h2000, 1'b0, 1'b1);
    chk("tp2_x0_we", reg_we, 32'd0);

    // PC wrap
    cyc(1'b1, 4'b0000, 32'h0, 5'd0, 32'h0, 32'hFFFFFFFC, 1'b0, 1'b1);
    chk("tp3_pc_wrap", pc_out, 32'h0);
    chk("tp3_done", done, 32'd1);

    // Nine OUT bytes into an 8-deep queue with no consumer
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 4'b1000, 32'h41 + i, 5'd0, 32'h0, 32'h400 + 4 * i, 1'b0, 1'b1);
      if (i == 8) chk("tp4_stall_done", done, 32'd0);
      else        chk("tp4_done", done, 32'd1);
    end
    idle(1'b1);
    chk("tp4_release_done", done, 32'd1);
    chk("tp4_head_after", out_data, 32'h42);
    for (int i = 0; i < 8; i++) begin
      chk("tp4_drain_order", out_data, 32'h42 + i);
      idle(1'b1);
    end
    chk("tp4_empty", out_valid, 32'd0);

    // Push into empty queue with consumer ready
    cyc(1'b1, 4'b1000, 32'h5A, 5'd0, 32'h0, 32'h500, 1'b1, 1'b1);
    chk("tp5_valid", out_valid, 32'd1);
    chk("tp5_byte", out_data, 32'h5A);
    idle(1'b1);
    // Fill, then push+pop at full
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 4'b1000, 32'h60 + i, 5'd0, 32'h0, 32'h600, 1'b0, 1'b1);
    cyc(1'b1, 4'b1000, 32'h70, 5'd0, 32'h0, 32'h700, 1'b1, 1'b1);
    chk("tp5_full_count", u_dut.u_fifo.count, 32'd8);
    chk("tp5_full_done", done, 32'd1);

    // Stall then reset mid-operation
    cyc(1'b1, 4'b1000, 32'h71, 5'd0, 32'h0, 32'h800, 1'b0, 1'b1);
    chk("tp6_stall", done, 32'd0);
    cyc(1'b0, 4'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("tp6_rst_valid", out_valid, 32'd0);
    chk("tp6_rst_done", done, 32'd0);
    chk("tp6_rst_pc", pc_out, 32'd0);
    idle(1'b1);
    chk("tp6_no_ghost", out_valid, 32'd0);
    cyc(1'b1, 4'b1000, 32'h77, 5'd0, 32'h0, 32'h900, 1'b0, 1'b1);
    chk("tp6_fresh_byte", out_data, 32'h77);
    chk("tp6_fresh_valid", out_valid, 32'd1);

    // Randomized bundles; enable withheld while the model is stalled
    for (int n = 0; n < 1500; n++) begin
      logic        en;
      logic [4:0]  rd;
      en = !m_stall && ($urandom_range(0, 9) < 5);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc(en, 4'($urandom), $urandom, rd, $urandom, $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) != 0));
    end

    // Drain remaining bytes
    for (int n = 0; n < 2 * OUT_DEPTH + 4; n++) idle(1'b1);
    chk("final_empty", out_valid, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
